// File: rtl/btn_step_gen_pkg.sv
// Shared definitions for the push-button step generator: FSM state encoding
// and default timing constants for a 100 MHz system clock.
package btn_step_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } state_t;

   localparam int unsigned DEF_HOLD_CYCLES   = 50_000_000;
   localparam int unsigned DEF_REPEAT_CYCLES = 10_000_000;
   localparam int unsigned DEF_RUN_DIV       = 25_000_000;
   localparam int unsigned DEF_TMR_W         = 26;
   localparam int unsigned DEF_CNT_W         = 16;

endpackage

// File: rtl/btn_tick_cnt.sv
// Up-counter with synchronous clear and enable; tc flags that the count has
// reached the caller-selected terminal value.
module btn_tick_cnt #(
   parameter int unsigned TMR_W = 26
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [TMR_W-1:0] term,
   output logic             tc
);

   logic [TMR_W-1:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (en) begin
         count_reg <= count_reg + TMR_W'(1);
      end
   end

   assign tc = (count_reg == term);

endmodule

// File: rtl/btn_step_gen.sv
// Turns a debounced button level into single-cycle step pulses with
// auto-repeat, or free-runs the step pulse in run mode; counts the pulses.
module btn_step_gen
   import btn_step_gen_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
   parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
   parameter int unsigned RUN_DIV       = DEF_RUN_DIV,
   parameter int unsigned TMR_W         = DEF_TMR_W,
   parameter int unsigned CNT_W         = DEF_CNT_W
) (
   input  logic             clk_100MHz,
   input  logic             rst_n,
   input  logic             btn_level,
   input  logic             run_mode,
   input  logic             cnt_clr,
   output logic             step_en,
   output logic [CNT_W-1:0] step_cnt,
   output logic             hold_active
);

   localparam logic [TMR_W-1:0] HOLD_TERM   = TMR_W'(HOLD_CYCLES - 1);
   localparam logic [TMR_W-1:0] REPEAT_TERM = TMR_W'(REPEAT_CYCLES - 1);
   localparam logic [TMR_W-1:0] RUN_TERM    = TMR_W'(RUN_DIV - 1);

   state_t           state_reg, state_next;
   logic             btn_q;
   logic             run_q;
   logic             step_en_reg, step_en_next;
   logic [CNT_W-1:0] step_cnt_reg;
   logic             hold_active_reg;
   logic             rise;
   logic             tmr_clr, tmr_en, tmr_tc;
   logic [TMR_W-1:0] tmr_term;

   assign rise = btn_level & ~btn_q;

   btn_tick_cnt #(.TMR_W(TMR_W)) u_tick (
      .clk   (clk_100MHz),
      .rst_n (rst_n),
      .clr   (tmr_clr),
      .en    (tmr_en),
      .term  (tmr_term),
      .tc    (tmr_tc)
   );

   always_comb begin
      state_next   = state_reg;
      step_en_next = 1'b0;
      tmr_clr      = 1'b0;
      tmr_en       = 1'b0;
      tmr_term     = HOLD_TERM;
      if (run_mode) begin
         // First run-mode cycle restarts the divider so the period is exact.
         state_next = ST_IDLE;
         tmr_term   = RUN_TERM;
         if (!run_q) begin
            tmr_clr = 1'b1;
         end else if (tmr_tc) begin
            step_en_next = 1'b1;
            tmr_clr      = 1'b1;
         end else begin
            tmr_en = 1'b1;
         end
      end else begin
         case (state_reg)
            ST_IDLE: begin
               tmr_clr = 1'b1;
               if (rise) begin
                  step_en_next = 1'b1;
                  state_next   = ST_HOLD;
               end
            end
            ST_HOLD: begin
               tmr_term = HOLD_TERM;
               if (!btn_level) begin
                  state_next = ST_IDLE;
                  tmr_clr    = 1'b1;
               end else if (tmr_tc) begin
                  step_en_next = 1'b1;
                  tmr_clr      = 1'b1;
                  state_next   = ST_REPEAT;
               end else begin
                  tmr_en = 1'b1;
               end
            end
            ST_REPEAT: begin
               tmr_term = REPEAT_TERM;
               if (!btn_level) begin
                  state_next = ST_IDLE;
                  tmr_clr    = 1'b1;
               end else if (tmr_tc) begin
                  step_en_next = 1'b1;
                  tmr_clr      = 1'b1;
               end else begin
                  tmr_en = 1'b1;
               end
            end
            default: begin
               state_next = ST_IDLE;
               tmr_clr    = 1'b1;
            end
         endcase
      end
   end

   // btn_q resets high so a button held through reset is not seen as a press.
   always_ff @(posedge clk_100MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= ST_IDLE;
         btn_q           <= 1'b1;
         run_q           <= 1'b0;
         step_en_reg     <= 1'b0;
         step_cnt_reg    <= '0;
         hold_active_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         btn_q           <= btn_level;
         run_q           <= run_mode;
         step_en_reg     <= step_en_next;
         hold_active_reg <= (state_next != ST_IDLE);
         if (cnt_clr) begin
            step_cnt_reg <= '0;
         end else if (step_en_reg) begin
            step_cnt_reg <= step_cnt_reg + CNT_W'(1);
         end
      end
   end

   assign step_en     = step_en_reg;
   assign step_cnt    = step_cnt_reg;
   assign hold_active = hold_active_reg;

endmodule

// File: tb/tb_btn_step_gen.sv
// Self-checking bench for btn_step_gen: pulse times are predicted from the
// press length with plain arithmetic and compared against observed pulses.
module tb_btn_step_gen;

   localparam int HOLD = 8;
   localparam int REP  = 4;
   localparam int RUN  = 3;
   localparam int CW   = 4;

   logic          clk_100MHz = 1'b0;
   logic          rst_n      = 1'b0;
   logic          btn_level  = 1'b0;
   logic          run_mode   = 1'b0;
   logic          cnt_clr    = 1'b0;
   logic          step_en;
   logic [CW-1:0] step_cnt;
   logic          hold_active;

   int   n_checks   = 0;
   int   n_fail     = 0;
   int   cyc        = 0;
   int   exp_cnt    = 0;
   int   ha_cycles  = 0;
   int   pulses[$];
   logic prev_en    = 1'b0;

   btn_step_gen #(
      .HOLD_CYCLES   (HOLD),
      .REPEAT_CYCLES (REP),
      .RUN_DIV       (RUN),
      .TMR_W         (8),
      .CNT_W         (CW)
   ) dut (
      .clk_100MHz  (clk_100MHz),
      .rst_n       (rst_n),
      .btn_level   (btn_level),
      .run_mode    (run_mode),
      .cnt_clr     (cnt_clr),
      .step_en     (step_en),
      .step_cnt    (step_cnt),
      .hold_active (hold_active)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   always @(posedge clk_100MHz) cyc <= cyc + 1;

   // Record the edge index that launched each pulse; pulses must never touch.
   always @(negedge clk_100MHz) begin
      if (step_en === 1'b1) begin
         pulses.push_back(cyc);
         n_checks++;
         if (prev_en !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back: step_en=1 at edge %0d, previous cycle step_en=%b, required 0", cyc, prev_en);
         end
      end
      if (hold_active === 1'b1) ha_cycles++;
      prev_en = step_en;
   end

   // Model: a press seen for len cycles gives the initial pulse, one after
   // HOLD cycles if still held then, then one every REP cycles while held.
   function automatic int n_pulses(input int len);
      if (len < HOLD + 1) return 1;
      return 2 + (len - HOLD - 1) / REP;
   endfunction

   function automatic int pulse_offset(input int k);
      return (k == 0) ? 0 : HOLD + REP * (k - 1);
   endfunction

   task automatic clocks(input int n);
      repeat (n) @(posedge clk_100MHz);
      #1;
   endtask

   task automatic press(input int len, input int gap, output int rise_edge);
      btn_level = 1'b1;
      rise_edge = cyc + 1;
      clocks(len);
      btn_level = 1'b0;
      clocks(gap);
   endtask

   task automatic test_reset;
      rst_n     = 1'b0;
      btn_level = 1'b1;
      #23;
      n_checks++;
      if (step_en !== 1'b0) begin n_fail++; $display("FAIL reset_step_en: got %b, required 0", step_en); end
      n_checks++;
      if (step_cnt !== '0) begin n_fail++; $display("FAIL reset_step_cnt: got %0d, required 0", step_cnt); end
      n_checks++;
      if (hold_active !== 1'b0) begin n_fail++; $display("FAIL reset_hold_active: got %b, required 0", hold_active); end
      @(posedge clk_100MHz);
      #2;
      rst_n = 1'b1;
      pulses.delete();
      ha_cycles = 0;
      clocks(20);
      n_checks++;
      if (pulses.size() != 0) begin n_fail++; $display("FAIL held_through_reset_pulses: got %0d pulses, required 0", pulses.size()); end
      n_checks++;
      if (step_cnt !== '0) begin n_fail++; $display("FAIL held_through_reset_cnt: got %0d, required 0", step_cnt); end
      n_checks++;
      if (ha_cycles != 0) begin n_fail++; $display("FAIL held_through_reset_hold: got %0d cycles, required 0", ha_cycles); end
      btn_level = 1'b0;
      clocks(2);
      exp_cnt = 0;
   endtask

   task automatic test_single_press;
      int r;
      pulses.delete();
      ha_cycles = 0;
      press(5, 3, r);
      exp_cnt += 1;
      n_checks++;
      if (pulses.size() != 1) begin n_fail++; $display("FAIL single_press_count: got %0d pulses, required 1", pulses.size()); end
      n_checks++;
      if (pulses.size() > 0 && pulses[0] != r) begin n_fail++; $display("FAIL single_press_time: got edge %0d, required %0d", pulses[0], r); end
      n_checks++;
      if (step_cnt !== CW'(exp_cnt)) begin n_fail++; $display("FAIL single_press_cnt: got %0d, required %0d", step_cnt, CW'(exp_cnt)); end
      n_checks++;
      if (ha_cycles != 5) begin n_fail++; $display("FAIL single_press_hold_active: got %0d cycles, required 5", ha_cycles); end
   endtask

   task automatic check_press(input string name, input int len, input int r);
      int n;
      n = n_pulses(len);
      exp_cnt += n;
      n_checks++;
      if (pulses.size() != n) begin n_fail++; $display("FAIL %s_count: len %0d got %0d pulses, required %0d", name, len, pulses.size(), n); end
      for (int k = 0; k < n && k < pulses.size(); k++) begin
         n_checks++;
         if (pulses[k] != r + pulse_offset(k)) begin
            n_fail++;
            $display("FAIL %s_time: pulse %0d got edge %0d, required %0d", name, k, pulses[k], r + pulse_offset(k));
         end
      end
      n_checks++;
      if (step_cnt !== CW'(exp_cnt)) begin n_fail++; $display("FAIL %s_cnt: got %0d, required %0d", name, step_cnt, CW'(exp_cnt)); end
   endtask

   task automatic test_hold_repeat;
      int r;
      pulses.delete();
      press(30, 3, r);
      check_press("hold_repeat", 30, r);
   endtask

   task automatic test_random_presses;
      int r, len, gap;
      for (int i = 0; i < 10; i++) begin
         len = $urandom_range(1, 26);
         gap = $urandom_range(1, 4);
         pulses.delete();
         press(len, gap, r);
         check_press("random_press", len, r);
      end
   endtask

   task automatic test_release_on_terminal;
      int r;
      pulses.delete();
      press(HOLD, 3, r);
      check_press("release_hold_tc", HOLD, r);
      pulses.delete();
      press(HOLD + 1, 3, r);
      check_press("release_after_hold_tc", HOLD + 1, r);
      pulses.delete();
      press(HOLD + REP, 3, r);
      check_press("release_repeat_tc", HOLD + REP, r);
   endtask

   task automatic test_run_mode;
      int m;
      pulses.delete();
      ha_cycles = 0;
      run_mode = 1'b1;
      m = cyc + 1;
      for (int i = 0; i < 13; i++) begin
         btn_level = (i < 11) ? 1'($urandom_range(0, 1)) : 1'b0;
         clocks(1);
      end
      run_mode = 1'b0;
      clocks(4);
      exp_cnt += 4;
      n_checks++;
      if (pulses.size() != 4) begin n_fail++; $display("FAIL run_mode_count: got %0d pulses, required 4", pulses.size()); end
      for (int k = 0; k < 4 && k < pulses.size(); k++) begin
         n_checks++;
         if (pulses[k] != m + RUN * (k + 1)) begin
            n_fail++;
            $display("FAIL run_mode_time: pulse %0d got edge %0d, required %0d", k, pulses[k], m + RUN * (k + 1));
         end
      end
      n_checks++;
      if (ha_cycles != 0) begin n_fail++; $display("FAIL run_mode_hold_active: got %0d cycles, required 0", ha_cycles); end
      n_checks++;
      if (step_cnt !== CW'(exp_cnt)) begin n_fail++; $display("FAIL run_mode_cnt: got %0d, required %0d", step_cnt, CW'(exp_cnt)); end
   endtask

   task automatic test_mode_exit_held;
      int r;
      run_mode  = 1'b1;
      btn_level = 1'b1;
      clocks(5);
      exp_cnt += 1;
      run_mode = 1'b0;
      clocks(1);
      pulses.delete();
      ha_cycles = 0;
      clocks(10);
      n_checks++;
      if (pulses.size() != 0) begin n_fail++; $display("FAIL mode_exit_held_pulses: got %0d pulses, required 0", pulses.size()); end
      n_checks++;
      if (ha_cycles != 0) begin n_fail++; $display("FAIL mode_exit_held_hold: got %0d cycles, required 0", ha_cycles); end
      btn_level = 1'b0;
      clocks(2);
      press(3, 2, r);
      check_press("mode_exit_repress", 3, r);
   endtask

   task automatic test_wrap_and_clear;
      int r;
      cnt_clr = 1'b1;
      clocks(1);
      cnt_clr = 1'b0;
      exp_cnt = 0;
      n_checks++;
      if (step_cnt !== '0) begin n_fail++; $display("FAIL clear_idle: got %0d, required 0", step_cnt); end
      for (int i = 0; i < 17; i++) press(2, 2, r);
      n_checks++;
      if (step_cnt !== CW'(17)) begin n_fail++; $display("FAIL wrap_cnt: got %0d, required %0d", step_cnt, CW'(17)); end
      btn_level = 1'b1;
      clocks(1);
      n_checks++;
      if (step_en !== 1'b1) begin n_fail++; $display("FAIL clear_pulse_present: got %b, required 1", step_en); end
      cnt_clr = 1'b1;
      clocks(1);
      cnt_clr   = 1'b0;
      btn_level = 1'b0;
      clocks(2);
      n_checks++;
      if (step_cnt !== '0) begin n_fail++; $display("FAIL clear_coincident: got %0d, required 0", step_cnt); end
   endtask

   task automatic test_async_reset;
      btn_level = 1'b1;
      clocks(12);
      @(negedge clk_100MHz);
      n_checks++;
      if (hold_active !== 1'b1) begin n_fail++; $display("FAIL async_pre_hold: got %b, required 1", hold_active); end
      n_checks++;
      if (step_cnt !== CW'(2)) begin n_fail++; $display("FAIL async_pre_cnt: got %0d, required 2", step_cnt); end
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (step_en !== 1'b0) begin n_fail++; $display("FAIL async_step_en: got %b, required 0", step_en); end
      n_checks++;
      if (step_cnt !== '0) begin n_fail++; $display("FAIL async_step_cnt: got %0d, required 0", step_cnt); end
      n_checks++;
      if (hold_active !== 1'b0) begin n_fail++; $display("FAIL async_hold_active: got %b, required 0", hold_active); end
      btn_level = 1'b0;
      clocks(2);
      rst_n = 1'b1;
      clocks(3);
      n_checks++;
      if (step_cnt !== '0) begin n_fail++; $display("FAIL async_post_cnt: got %0d, required 0", step_cnt); end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_hold_repeat();
      test_random_presses();
      test_release_on_terminal();
      test_run_mode();
      test_mode_exit_held();
      test_wrap_and_clear();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
